// File: rtl/alu_divider.sv
// Multi-cycle unsigned restoring divider: DIVIDEND_W / DIVISOR_W -> quotient, remainder.
// Optional macro ALU_DIV_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module alu_divider #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned RW    = DIVISOR_W + 1;
    localparam int unsigned PW    = DIVISOR_W + 2;
    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  dbz_q, dbz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PW-1:0]         partial;
    logic                  ge;
    logic [RW-1:0]         rem_step;
    logic [DIVIDEND_W-1:0] dvd_step;

    // One restoring step; the dividend register doubles as the quotient shift register.
    always_comb begin
        partial  = {rem_q, dvd_q[DIVIDEND_W-1]};
        ge       = (partial >= PW'(dsr_q));
        rem_step = ge ? RW'(partial - PW'(dsr_q)) : RW'(partial);
        dvd_step = {dvd_q[DIVIDEND_W-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_RUN: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d = S_DONE;
                    quo_d   = dvd_step;
                    rmd_d   = DIVISOR_W'(rem_step);
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation
                state_d = S_IDLE;
                if (start) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rmd_d   = '0;
                        dbz_d   = 1'b1;
                    end
`ifdef ALU_DIV_EARLY_EXIT_EN
                    else if (dividend < DIVIDEND_W'(divisor)) begin
                        state_d = S_DONE;
                        quo_d   = '0;
                        rmd_d   = dividend[DIVISOR_W-1:0];
                    end
`endif
                    else begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_divider.sv
// Randomized self-checking bench for alu_divider against an arithmetic reference model.
module tb_alu_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;
    int prev_q = 0;
    int prev_r = 0;

    alu_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one division and follow it to its done pulse; ends inside the done cycle.
    task automatic run_op(input int a, input int b, input int poke_at);
        int exp_q, exp_r, exp_z, exp_lat, lat;
        bit early;
`ifdef ALU_DIV_EARLY_EXIT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        exp_z   = (b == 0) ? 1 : 0;
        exp_q   = (b == 0) ? 255 : a / b;
        exp_r   = (b == 0) ? 0 : a % b;
        exp_lat = (b == 0 || (early && a < b)) ? 1 : 9;

        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            check("busy_run", int'(busy), 1);
            check("q_hold", int'(quotient), prev_q);
            check("r_hold", int'(remainder), prev_r);
            if (lat == poke_at) begin
                start    = 1'b1;
                dividend = 8'd100;
                divisor  = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", int'(done), 1);
        check("latency", lat, exp_lat);
        check("busy_at_done", int'(busy), 0);
        check("quotient", int'(quotient), exp_q);
        check("remainder", int'(remainder), exp_r);
        check("div_by_zero", int'(div_by_zero), exp_z);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a, b, gap;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd9;
        @(posedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        @(posedge clk); #1;
        check("idle_busy", int'(busy), 0);

        run_op(200, 9, 0);
        run_op(255, 15, 0);
        run_op(90, 9, 0);
        @(posedge clk); #1;
        check("done_pulse_end", int'(done), 0);

        run_op(37, 0, 0);
        run_op(37, 5, 0);

        run_op(200, 9, 3);
        @(posedge clk); #1;
        check("no_second_done", int'(done), 0);
        check("no_second_busy", int'(busy), 0);

        // Reset in the middle of a run aborts it
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        prev_q = 0;
        prev_r = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", int'(done), 0);
        end
        run_op(255, 1, 0);
        run_op(7, 9, 0);

        for (int i = 0; i < 80; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                check("gap_done", int'(done), 0);
                check("gap_busy", int'(busy), 0);
            end
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 15);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            run_op(a, b, 0);
        end

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle unsigned restoring divider that sits beside the 4-bit combinational ALU.
- Provides the inverse of the ALU multiply: an 8-bit product-width dividend divided by a 4-bit operand-width divisor gives a quotient and remainder.
- One quotient bit is produced per cycle. A start/busy/done handshake lets a controller issue operations and collect results.

Parameters:
- DIVIDEND_W, 8: dividend and quotient width; equals the ALU result width.
- DIVISOR_W, 4: divisor and remainder width; equals the ALU operand width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new division; sampled only when busy=0.
- dividend  input  DIVIDEND_W  numerator; latched on an accepted start.
- divisor  input  DIVISOR_W  denominator; latched on an accepted start.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse: results are valid.
- quotient  output  DIVIDEND_W  result quotient; held until the next accepted start.
- remainder  output  DIVISOR_W  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the latched divisor was 0; held with the results.

Behaviour:
- Reset:
  - Reset is synchronous and active-high, and the block is on a single clock (clk).
  - rst=1 at an edge forces state IDLE and clears all outputs to 0, including the internal shift, remainder and count registers.
  - Reset wins over start in the same cycle.
  - Reset mid-RUN aborts the operation, and no done is produced.
- States:
  - IDLE: busy=0, done=0. start=1 latches the operands and clears the count. If divisor==0, go to DONE; otherwise go to RUN.
  - RUN: busy=1. Each cycle performs one restoring step:
    - partial = {rem_reg, dividend MSB}, with rem_reg DIVISOR_W+1 bits wide.
    - if partial >= divisor: subtract divisor and shift in quotient bit 1; otherwise shift in 0.
    - shift the dividend left by 1 and increment the count.
    - after DIVIDEND_W steps, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, outputs valid. Next state is IDLE. A start in this cycle is accepted exactly as in IDLE (back-to-back operation).
- Latency: for start accepted at edge T, busy=1 for cycles T+1..T+DIVIDEND_W and done=1 in cycle T+DIVIDEND_W+1.
- Output update rule: quotient and remainder update only on entry to DONE. Between operations they hold their last values; the quotient/remainder from the previous operation stay visible during RUN.
- Divide by zero: done at T+1 with quotient = all ones, remainder = 0, div_by_zero=1.
- div_by_zero clear rule: cleared on the next accepted start.
- start while busy=1: ignored; operands are not re-latched and there is no effect on the current operation.
- Input stability: operand changes after acceptance have no effect.
- Arithmetic: unsigned only. The remainder is always < divisor and fits in DIVISOR_W bits. The invariant quotient*divisor + remainder == dividend holds for every nonzero divisor.

Optional Feature:
- Macro: ALU_DIV_EARLY_EXIT_EN
- Defined:
  - In IDLE, an accepted start with divisor!=0 and dividend < divisor goes directly to DONE.
  - The results are quotient=0 and remainder=dividend[DIVISOR_W-1:0].
  - done arrives at T+1.
- Undefined: every nonzero-divisor operation takes the full DIVIDEND_W+1 cycle latency. Results are identical in both builds; only the timing differs.

Test Plan:
- Reset, then dividend=200, divisor=9, start for 1 cycle -> busy high for 8 cycles, done at T+9, quotient=22, remainder=2, div_by_zero=0.
- dividend=255, divisor=15, then immediately on done pulse dividend=90, divisor=9, start -> first result 17 r0. Back-to-back result 10 r0 at 9 cycles after the second start.
- dividend=37, divisor=0 -> done at T+1, quotient=255, remainder=0, div_by_zero=1. A following 37/5 gives 7 r2 with div_by_zero=0.
- Start 200/9, then pulse start with 100/3 at T+3 -> second start ignored, result 22 r2 at T+9, no second done.
- Start 200/9, assert rst at T+4 -> busy=0, outputs 0, no done. Then 255/1 -> 255 r0 after 9 cycles.
- dividend=7, divisor=9 -> result 0 r7 in both builds. Done at T+1 with ALU_DIV_EARLY_EXIT_EN defined, at T+9 without it.
